// File: rtl/neuron_act_buffer.sv
// Post-MAC activation stage: bias add, saturating (ReLU) activation, frame buffer,
// argmax tracking, and a valid/ready drain of one layer's activations.

module neuron_act_sat #(
    parameter int DATA_W  = 16,
    parameter bit RELU_EN = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    logic [DATA_W:0] sum;

    assign sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};

    // sum[DATA_W] is the true sign; a mismatch with sum[DATA_W-1] means out of Q8.8 range
    always_comb begin
        y = sum[DATA_W-1:0];
        if (!sum[DATA_W] && sum[DATA_W-1]) begin
            y = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (sum[DATA_W]) begin
            if (RELU_EN)
                y = '0;
            else if (!sum[DATA_W-1])
                y = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
endmodule

module neuron_act_buffer #(
    parameter int NUM_NEURONS = 10,
    parameter int DATA_W      = 16,
    parameter int RELU_EN     = 1,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              bias_wr_en,
    input  logic [IDX_W-1:0]  bias_addr,
    input  logic [DATA_W-1:0] bias_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_val
);
    typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

    state_t state, state_nxt;

    logic [NUM_NEURONS-1:0][DATA_W-1:0] bias;
    logic [NUM_NEURONS-1:0][DATA_W-1:0] buffer;
    logic [IDX_W-1:0]  in_count;
    logic [IDX_W-1:0]  drain_ptr;
    logic [DATA_W-1:0] max_val;
    logic [IDX_W-1:0]  max_idx;
    logic [DATA_W-1:0] act_val;
    logic              accept;
    logic              xfer;
    logic              bias_hit;

    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid && out_ready;
    assign bias_hit = bias_wr_en && (32'(bias_addr) < NUM_NEURONS);

    // Reads the pre-write bias, so a colliding bias write lands after this accept
    neuron_act_sat #(
        .DATA_W  (DATA_W),
        .RELU_EN (RELU_EN != 0)
    ) u_act (
        .a (in_data),
        .b (bias[in_count]),
        .y (act_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: if (accept && in_count == LAST) state_nxt = S_DRAIN;
            S_DRAIN:   if (xfer && drain_ptr == LAST)  state_nxt = S_DONE;
            S_DONE:    state_nxt = S_COLLECT;
            default:   state_nxt = S_COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_index = '0;
        done      = 1'b0;
        case (state)
            S_COLLECT: in_ready = 1'b1;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = buffer[drain_ptr];
                out_index = drain_ptr;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bias      <= '0;
            buffer    <= '0;
            in_count  <= '0;
            drain_ptr <= '0;
            max_val   <= '0;
            max_idx   <= '0;
            class_idx <= '0;
            class_val <= '0;
        end else begin
            if (bias_hit)
                bias[bias_addr] <= bias_data;

            if (accept) begin
                buffer[in_count] <= act_val;
                in_count         <= (in_count == LAST) ? '0 : in_count + 1'b1;
                // Strict compare keeps the lowest index on ties
                if (in_count == '0 || $signed(act_val) > $signed(max_val)) begin
                    max_val <= act_val;
                    max_idx <= in_count;
                end
            end

            if (xfer)
                drain_ptr <= (drain_ptr == LAST) ? '0 : drain_ptr + 1'b1;

            if (state == S_DONE) begin
                class_idx <= max_idx;
                class_val <= max_val;
                max_val   <= '0;
                max_idx   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_neuron_act_buffer.sv
// Directed bench: two 4-neuron instances (ReLU on / off) share stimulus;
// table-driven frames plus hand sequences for backpressure, reset and bias collision.

module tb_neuron_act_buffer;
    typedef logic [3:0][15:0] quad_t;

    typedef struct {
        string       name;
        quad_t       b;
        quad_t       d;
        quad_t       er;
        quad_t       en;
        logic [1:0]  cr;
        logic [15:0] vr;
        logic [1:0]  cn;
        logic [15:0] vn;
    } vec_t;

    logic        clk, reset;
    logic        in_valid, bias_wr_en, out_ready;
    logic [15:0] in_data, bias_data;
    logic [1:0]  bias_addr;
    logic        in_ready, out_valid, done;
    logic [15:0] out_data, class_val;
    logic [1:0]  out_index, class_idx;
    logic        n_in_ready, n_out_valid, n_done;
    logic [15:0] n_out_data, n_class_val;
    logic [1:0]  n_out_index, n_class_idx;

    int nvec  = 0;
    int nfail = 0;

    neuron_act_buffer #(.NUM_NEURONS(4), .DATA_W(16), .RELU_EN(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .bias_wr_en(bias_wr_en), .bias_addr(bias_addr), .bias_data(bias_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .done(done), .class_idx(class_idx), .class_val(class_val)
    );

    neuron_act_buffer #(.NUM_NEURONS(4), .DATA_W(16), .RELU_EN(0)) dut_nr (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(n_in_ready),
        .bias_wr_en(bias_wr_en), .bias_addr(bias_addr), .bias_data(bias_data),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .out_index(n_out_index), .done(n_done), .class_idx(n_class_idx), .class_val(n_class_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic quad_t q(input logic [15:0] a0, input logic [15:0] a1,
                                input logic [15:0] a2, input logic [15:0] a3);
        quad_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_bias(input quad_t b);
        for (int i = 0; i < 4; i++) begin
            bias_wr_en = 1'b1;
            bias_addr  = 2'(i);
            bias_data  = b[i];
            step();
        end
        bias_wr_en = 1'b0;
    endtask

    task automatic feed(input quad_t d);
        for (int i = 0; i < 4; i++) begin
            chk("in_ready_collect", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = d[i];
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int first, input quad_t er, input quad_t en,
                         input logic [1:0] cr, input logic [15:0] vr,
                         input logic [1:0] cn, input logic [15:0] vn);
        out_ready = 1'b1;
        for (int i = first; i < 4; i++) begin
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("in_ready_drain", 32'(in_ready), 32'd0);
            chk("out_index", 32'(out_index), 32'(i));
            chk("out_data", 32'(out_data), 32'(er[i]));
            chk("nr_out_index", 32'(n_out_index), 32'(i));
            chk("nr_out_data", 32'(n_out_data), 32'(en[i]));
            step();
        end
        out_ready = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("out_valid_done", 32'(out_valid), 32'd0);
        chk("nr_done_pulse", 32'(n_done), 32'd1);
        step();
        chk("done_clear", 32'(done), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("class_idx", 32'(class_idx), 32'(cr));
        chk("class_val", 32'(class_val), 32'(vr));
        chk("nr_class_idx", 32'(n_class_idx), 32'(cn));
        chk("nr_class_val", 32'(n_class_val), 32'(vn));
    endtask

    vec_t v[4];

    initial begin
        v[0] = '{"basic", q(16'h0080, 16'h0000, 16'h0000, 16'h0000),
                 q(16'h0180, 16'h0100, 16'h0040, 16'h0000),
                 q(16'h0200, 16'h0100, 16'h0040, 16'h0000),
                 q(16'h0200, 16'h0100, 16'h0040, 16'h0000),
                 2'd0, 16'h0200, 2'd0, 16'h0200};
        v[1] = '{"relu_sat", q(16'h0000, 16'h0200, 16'hFE00, 16'h0000),
                 q(16'hFF00, 16'h7F00, 16'h8100, 16'h0010),
                 q(16'h0000, 16'h7FFF, 16'h0000, 16'h0010),
                 q(16'hFF00, 16'h7FFF, 16'h8000, 16'h0010),
                 2'd1, 16'h7FFF, 2'd1, 16'h7FFF};
        v[2] = '{"tie", q(16'h0000, 16'h0000, 16'h0000, 16'h0000),
                 q(16'h0300, 16'h0500, 16'h0500, 16'h0100),
                 q(16'h0300, 16'h0500, 16'h0500, 16'h0100),
                 q(16'h0300, 16'h0500, 16'h0500, 16'h0100),
                 2'd1, 16'h0500, 2'd1, 16'h0500};
        v[3] = '{"all_neg", q(16'h0000, 16'h0000, 16'h0000, 16'h0000),
                 q(16'hFF00, 16'hFE00, 16'h8000, 16'hFFFF),
                 q(16'h0000, 16'h0000, 16'h0000, 16'h0000),
                 q(16'hFF00, 16'hFE00, 16'h8000, 16'hFFFF),
                 2'd0, 16'h0000, 2'd3, 16'hFFFF};

        reset = 1'b1;
        in_valid = 1'b0; in_data = '0;
        bias_wr_en = 1'b0; bias_addr = '0; bias_data = '0;
        out_ready = 1'b0;
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_class_idx", 32'(class_idx), 32'd0);
        chk("rst_class_val", 32'(class_val), 32'd0);
        reset = 1'b0;
        step();

        for (int k = 0; k < 4; k++) begin
            write_bias(v[k].b);
            feed(v[k].d);
            drain(0, v[k].er, v[k].en, v[k].cr, v[k].vr, v[k].cn, v[k].vn);
        end

        // Backpressure: stall three cycles after the first beat
        write_bias(q(16'h0000, 16'h0000, 16'h0000, 16'h0000));
        feed(q(16'h0010, 16'h0020, 16'h0030, 16'h0040));
        out_ready = 1'b1;
        chk("bp_beat0_idx", 32'(out_index), 32'd0);
        chk("bp_beat0_data", 32'(out_data), 32'h0010);
        step();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_idx", 32'(out_index), 32'd1);
            chk("bp_hold_data", 32'(out_data), 32'h0020);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        drain(1, q(16'h0010, 16'h0020, 16'h0030, 16'h0040),
              q(16'h0010, 16'h0020, 16'h0030, 16'h0040), 2'd3, 16'h0040, 2'd3, 16'h0040);

        // Reset after two drain beats
        write_bias(q(16'h0080, 16'h0000, 16'h0000, 16'h0000));
        feed(q(16'h0180, 16'h0100, 16'h0040, 16'h0000));
        out_ready = 1'b1;
        chk("rd_beat0", 32'(out_data), 32'h0200);
        step();
        chk("rd_beat1", 32'(out_data), 32'h0100);
        step();
        reset = 1'b1;
        #1;
        chk("rd_out_valid", 32'(out_valid), 32'd0);
        chk("rd_out_data", 32'(out_data), 32'd0);
        chk("rd_out_index", 32'(out_index), 32'd0);
        chk("rd_in_ready", 32'(in_ready), 32'd1);
        chk("rd_done", 32'(done), 32'd0);
        chk("rd_class_idx", 32'(class_idx), 32'd0);
        chk("rd_class_val", 32'(class_val), 32'd0);
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("rd_no_done", 32'(done), 32'd0);
        chk("rd_collect", 32'(in_ready), 32'd1);
        // Biases were cleared, so this frame passes inputs straight through
        feed(q(16'h0180, 16'h0100, 16'h0040, 16'h0000));
        drain(0, q(16'h0180, 16'h0100, 16'h0040, 16'h0000),
              q(16'h0180, 16'h0100, 16'h0040, 16'h0000), 2'd0, 16'h0180, 2'd0, 16'h0180);
        write_bias(q(16'h0080, 16'h0000, 16'h0000, 16'h0000));
        feed(q(16'h0180, 16'h0100, 16'h0040, 16'h0000));
        drain(0, v[0].er, v[0].en, 2'd0, 16'h0200, 2'd0, 16'h0200);

        // Bias write colliding with accept at index 0 uses the old bias
        write_bias(q(16'h0000, 16'h0000, 16'h0000, 16'h0000));
        bias_wr_en = 1'b1; bias_addr = 2'd0; bias_data = 16'h0100;
        in_valid = 1'b1; in_data = 16'h0100;
        step();
        bias_wr_en = 1'b0;
        for (int i = 1; i < 4; i++) begin
            in_data = 16'h0000;
            step();
        end
        in_valid = 1'b0;
        drain(0, q(16'h0100, 16'h0000, 16'h0000, 16'h0000),
              q(16'h0100, 16'h0000, 16'h0000, 16'h0000), 2'd0, 16'h0100, 2'd0, 16'h0100);
        feed(q(16'h0100, 16'h0000, 16'h0000, 16'h0000));
        drain(0, q(16'h0200, 16'h0000, 16'h0000, 16'h0000),
              q(16'h0200, 16'h0000, 16'h0000, 16'h0000), 2'd0, 16'h0200, 2'd0, 16'h0200);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
